// File: rtl/spi_slave_capture_monitor.sv
// +------------------------------------------------------------------------+
// | spi_slave_capture_monitor: oversampled SPI slave-side bus monitor that |
// | reassembles MOSI/MISO words into a first-word-fall-through FIFO.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module spi_slave_capture_monitor #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            pclk,
  input  logic                            reset,
  input  logic                            cfg_cpol,
  input  logic                            cfg_cpha,
  input  logic                            cfg_lsb_first,
  input  logic [1:0]                      cfg_lanes,
  input  logic                            sclk,
  input  logic                            cs,
  input  logic [3:0]                      mosi,
  input  logic [3:0]                      miso,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_mosi_data,
  output logic [DATA_WIDTH-1:0]           out_miso_data,
  output logic [$clog2(DATA_WIDTH):0]     out_bit_count,
  output logic                            out_partial,
  output logic                            overflow,
  input  logic                            clear_overflow
);

  localparam int c_cw = $clog2(DATA_WIDTH) + 1;
  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_ew = 2 * DATA_WIDTH + c_cw + 1;
  localparam logic [c_cw-1:0] c_dw = c_cw'(DATA_WIDTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  // cs chain resets low so a cs held low through reset never looks like a falling edge
  logic [SYNC_STAGES-1:0]      r_sclk_sync, r_cs_sync;
  logic [SYNC_STAGES-1:0][3:0] r_mosi_sync, r_miso_sync;
  logic                        r_sclk_prev, r_cs_prev;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_miso_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], miso};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;

  state_t r_state, w_state_nxt;
  logic   w_frame_start, w_frame_end;

  always_ff @(posedge pclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_cs_fall) begin
        w_state_nxt   = ST_ACTIVE;
        w_frame_start = 1'b1;
      end
      ST_ACTIVE: if (w_cs_rise) begin
        w_state_nxt = ST_IDLE;
        w_frame_end = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic                  r_sample_fall, r_lsb_first;
  logic [1:0]            r_lanes;
  logic [DATA_WIDTH-1:0] r_mosi_sr, r_miso_sr;
  logic [c_cw-1:0]       r_cnt;

  logic [2:0]            w_lane_n;
  logic [3:0]            w_lane_mask;
  logic [DATA_WIDTH-1:0] w_mosi_in, w_miso_in, w_mosi_sh, w_miso_sh;
  logic [c_cw-1:0]       w_cnt_nxt, w_top_sh, w_part_sh;
  logic                  w_sample;

  always_comb begin
    w_lane_n    = 3'd1;
    w_lane_mask = 4'b0001;
    case (r_lanes)
      2'd1:    begin w_lane_n = 3'd2; w_lane_mask = 4'b0011; end
      2'd2:    begin w_lane_n = 3'd4; w_lane_mask = 4'b1111; end
      default: begin w_lane_n = 3'd1; w_lane_mask = 4'b0001; end
    endcase
  end

  assign w_sample  = (r_state == ST_ACTIVE) && !w_cs_rise &&
                     (r_sample_fall ? w_sclk_fall : w_sclk_rise);
  assign w_mosi_in = DATA_WIDTH'(r_mosi_sync[SYNC_STAGES-1] & w_lane_mask);
  assign w_miso_in = DATA_WIDTH'(r_miso_sync[SYNC_STAGES-1] & w_lane_mask);
  assign w_cnt_nxt = r_cnt + c_cw'(w_lane_n);
  assign w_top_sh  = c_dw - c_cw'(w_lane_n);
  assign w_part_sh = c_dw - r_cnt;
  // LSB-first fills from the top; MSB-first fills from the bottom
  assign w_mosi_sh = r_lsb_first ? ((r_mosi_sr >> w_lane_n) | (w_mosi_in << w_top_sh))
                                 : ((r_mosi_sr << w_lane_n) | w_mosi_in);
  assign w_miso_sh = r_lsb_first ? ((r_miso_sr >> w_lane_n) | (w_miso_in << w_top_sh))
                                 : ((r_miso_sr << w_lane_n) | w_miso_in);

  logic             r_wr_en;
  logic [c_ew-1:0]  r_wr_data;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_sample_fall <= 1'b0;
      r_lsb_first   <= 1'b0;
      r_lanes       <= 2'd0;
      r_mosi_sr     <= '0;
      r_miso_sr     <= '0;
      r_cnt         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_data     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_frame_start) begin
        r_sample_fall <= cfg_cpol ^ cfg_cpha;
        r_lsb_first   <= cfg_lsb_first;
        r_lanes       <= cfg_lanes;
        r_mosi_sr     <= '0;
        r_miso_sr     <= '0;
        r_cnt         <= '0;
      end else if (w_frame_end) begin
        if (r_cnt != '0) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= r_lsb_first ? {1'b1, r_cnt, r_miso_sr >> w_part_sh, r_mosi_sr >> w_part_sh}
                                   : {1'b1, r_cnt, r_miso_sr, r_mosi_sr};
        end
        r_cnt <= '0;
      end else if (w_sample) begin
        if (w_cnt_nxt == c_dw) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= {1'b0, c_dw, w_miso_sh, w_mosi_sh};
          r_mosi_sr <= '0;
          r_miso_sr <= '0;
          r_cnt     <= '0;
        end else begin
          r_mosi_sr <= w_mosi_sh;
          r_miso_sr <= w_miso_sh;
          r_cnt     <= w_cnt_nxt;
        end
      end
    end
  end

  logic [c_ew-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wptr, r_rptr;
  logic [c_aw:0]   r_count;
  logic            w_full, w_pop, w_push_ok, w_drop;
  logic [c_ew-1:0] w_head;

  assign w_full    = (r_count == (c_aw+1)'(FIFO_DEPTH));
  assign w_pop     = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push_ok = r_wr_en & (~w_full | w_pop);
  assign w_drop    = r_wr_en & w_full & ~w_pop;

  always_ff @(posedge pclk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_wr_data;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + c_aw'(1);
      if (w_pop)     r_rptr <= r_rptr + c_aw'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign w_head        = r_mem[r_rptr];
  assign out_valid     = (r_count != '0);
  assign out_mosi_data = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign out_miso_data = out_valid ? w_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign out_bit_count = out_valid ? w_head[2*DATA_WIDTH+c_cw-1:2*DATA_WIDTH] : '0;
  assign out_partial   = out_valid & w_head[c_ew-1];

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_capture_monitor.sv
// +------------------------------------------------------------------------+
// | tb_spi_slave_capture_monitor: directed self-checking bench.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_spi_slave_capture_monitor;

  logic       pclk = 1'b0;
  logic       reset, cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [1:0] cfg_lanes;
  logic       sclk, cs;
  logic [3:0] mosi, miso;
  logic       out_valid, out_ready, out_partial, overflow, clear_overflow;
  logic [7:0] out_mosi_data, out_miso_data;
  logic [3:0] out_bit_count;

  int  n_cmp = 0;
  int  n_err = 0;
  logic cur_cpha = 1'b0;

  always #5 pclk = ~pclk;

  spi_slave_capture_monitor #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_dut (
    .pclk(pclk), .reset(reset), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_lanes(cfg_lanes), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .out_valid(out_valid), .out_ready(out_ready),
    .out_mosi_data(out_mosi_data), .out_miso_data(out_miso_data),
    .out_bit_count(out_bit_count), .out_partial(out_partial),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_begin(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] lanes);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_lanes = lanes;
    cur_cpha = cpha;
    sclk = cpol;
    repeat (4) @(negedge pclk);
    cs = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge pclk);
    cs = 1'b1;
    repeat (6) @(negedge pclk);
  endtask

  // Data is valid only around the sample edge; the other edge sees the inverse.
  task automatic beat(input logic [3:0] mo, input logic [3:0] mi);
    mosi = cur_cpha ? ~mo : mo;
    miso = cur_cpha ? ~mi : mi;
    repeat (4) @(negedge pclk);
    sclk = ~sclk;
    repeat (2) @(negedge pclk);
    mosi = cur_cpha ? mo : ~mo;
    miso = cur_cpha ? mi : ~mi;
    repeat (2) @(negedge pclk);
    sclk = ~sclk;
    repeat (2) @(negedge pclk);
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi);
    for (int i = 7; i >= 0; i--) beat({3'b0, mo[i]}, {3'b0, mi[i]});
  endtask

  task automatic expect_word(input string tag, input logic [7:0] mo, input logic [7:0] mi,
                             input logic [3:0] cnt, input logic part);
    int t = 0;
    while (!out_valid && t < 300) begin
      @(negedge pclk);
      t++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mosi"}, 32'(out_mosi_data), 32'(mo));
    check({tag, "_miso"}, 32'(out_miso_data), 32'(mi));
    check({tag, "_cnt"}, 32'(out_bit_count), 32'(cnt));
    check({tag, "_part"}, 32'(out_partial), 32'(part));
    if (out_valid) begin
      out_ready = 1'b1;
      @(negedge pclk);
      out_ready = 1'b0;
    end
  endtask

  // Send all but the last bit of a mode-0 MSB-first byte, then raise sclk for the last sample.
  task automatic byte_to_last_edge(input logic [7:0] mo, input logic [7:0] mi);
    frame_begin(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 7; i >= 1; i--) beat({3'b0, mo[i]}, {3'b0, mi[i]});
    mosi = {3'b0, mo[0]};
    miso = {3'b0, mi[0]};
    repeat (4) @(negedge pclk);
    sclk = 1'b1;
  endtask

  task automatic finish_last_edge();
    repeat (2) @(negedge pclk);
    sclk = 1'b0;
    frame_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [7:0] mo, mi;
    reset = 1'b1; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_lanes = 0;
    sclk = 0; cs = 1; mosi = 0; miso = 0; out_ready = 0; clear_overflow = 0;
    repeat (5) @(negedge pclk);
    reset = 1'b0;
    @(negedge pclk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_mosi", 32'(out_mosi_data), 0);
    check("rst_miso", 32'(out_miso_data), 0);
    check("rst_cnt", 32'(out_bit_count), 0);
    check("rst_part", 32'(out_partial), 0);
    check("rst_ovf", 32'(overflow), 0);

    frame_begin(0, 0, 0, 2'd0);
    send_byte(8'hA5, 8'h3C);
    frame_end();
    expect_word("m0_single", 8'hA5, 8'h3C, 4'd8, 1'b0);
    repeat (20) @(negedge pclk);
    check("m0_no_extra", 32'(out_valid), 0);

    frame_begin(0, 0, 0, 2'd1);
    beat(4'h2, 4'h0); beat(4'h2, 4'h3); beat(4'h1, 4'h3); beat(4'h1, 4'h0);
    frame_end();
    expect_word("m0_dual", 8'hA5, 8'h3C, 4'd8, 1'b0);

    frame_begin(1, 1, 1, 2'd2);
    beat(4'h5, 4'h3); beat(4'hA, 4'hC);
    frame_end();
    expect_word("m3_quad", 8'hA5, 8'hC3, 4'd8, 1'b0);

    frame_begin(0, 1, 1, 2'd2);
    beat(4'h5, 4'h3); beat(4'hA, 4'hC);
    frame_end();
    expect_word("m1_quad", 8'hA5, 8'hC3, 4'd8, 1'b0);

    frame_begin(1, 0, 1, 2'd2);
    beat(4'h5, 4'h3); beat(4'hA, 4'hC);
    frame_end();
    expect_word("m2_quad", 8'hA5, 8'hC3, 4'd8, 1'b0);

    frame_begin(0, 0, 0, 2'd0);
    beat(1, 0); beat(0, 1); beat(1, 1); beat(1, 1); beat(0, 1);
    frame_end();
    expect_word("part_msb", 8'h16, 8'h0F, 4'd5, 1'b1);

    frame_begin(0, 0, 1, 2'd0);
    beat(1, 0); beat(0, 1); beat(1, 1); beat(1, 1); beat(0, 1);
    frame_end();
    expect_word("part_lsb", 8'h0D, 8'h1E, 4'd5, 1'b1);

    for (int k = 1; k <= 5; k++) begin
      frame_begin(0, 0, 0, 2'd0);
      send_byte(8'(k * 8'h11), ~8'(k * 8'h11));
      frame_end();
    end
    repeat (20) @(negedge pclk);
    check("ovf_set", 32'(overflow), 1);
    expect_word("ovf_w1", 8'h11, 8'hEE, 4'd8, 1'b0);
    expect_word("ovf_w2", 8'h22, 8'hDD, 4'd8, 1'b0);
    expect_word("ovf_w3", 8'h33, 8'hCC, 4'd8, 1'b0);
    expect_word("ovf_w4", 8'h44, 8'hBB, 4'd8, 1'b0);
    repeat (5) @(negedge pclk);
    check("ovf_empty", 32'(out_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clear_overflow = 1'b1;
    @(negedge pclk);
    clear_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // Measure push latency from the last sample edge, then reuse it to pop in the push cycle.
    mo = 8'h70; mi = 8'h8F;
    byte_to_last_edge(mo, mi);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge pclk);
      lat++;
    end
    check("cal_valid", 32'(out_valid), 1);
    finish_last_edge();
    expect_word("cal", 8'h70, 8'h8F, 4'd8, 1'b0);

    for (int k = 1; k <= 4; k++) begin
      frame_begin(0, 0, 0, 2'd0);
      send_byte(8'(8'h60 + k), 8'(8'h90 + k));
      frame_end();
    end
    mo = 8'h65; mi = 8'h95;
    byte_to_last_edge(mo, mi);
    repeat (lat - 1) @(negedge pclk);
    check("simul_head", 32'(out_mosi_data), 32'h61);
    out_ready = 1'b1;
    @(negedge pclk);
    out_ready = 1'b0;
    finish_last_edge();
    check("simul_ovf", 32'(overflow), 0);
    expect_word("simul_w2", 8'h62, 8'h92, 4'd8, 1'b0);
    expect_word("simul_w3", 8'h63, 8'h93, 4'd8, 1'b0);
    expect_word("simul_w4", 8'h64, 8'h94, 4'd8, 1'b0);
    expect_word("simul_w5", 8'h65, 8'h95, 4'd8, 1'b0);
    repeat (5) @(negedge pclk);
    check("simul_empty", 32'(out_valid), 0);

    frame_begin(0, 0, 0, 2'd0);
    beat(1, 0); beat(1, 0); beat(1, 0);
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    beat(0, 1); beat(0, 1); beat(1, 1); beat(0, 0); beat(1, 1);
    frame_end();
    repeat (30) @(negedge pclk);
    check("rstmid_none", 32'(out_valid), 0);

    frame_begin(0, 0, 0, 2'd0);
    cfg_cpol = 1'b1;
    send_byte(8'h5A, 8'hC3);
    frame_end();
    cfg_cpol = 1'b0;
    expect_word("rstmid_clean", 8'h5A, 8'hC3, 4'd8, 1'b0);
    repeat (20) @(negedge pclk);
    check("rstmid_single", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
